// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed multi-channel FIR controller sharing one multiplier and accumulator
module fir_mac_sequencer #(
  parameter int W = 32,
  parameter int W_FRAC = 16,
  parameter int N = 41,
  parameter int NCH = 2,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [W-1:0]  x_data,
  input  logic [CW-1:0] x_chan,
  output logic [AW-1:0] coef_addr,
  input  logic [W-1:0]  coef_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [W-1:0]  y_data,
  output logic [CW-1:0] y_chan,
  output logic          y_sat
);
  localparam int MW = $clog2(N * NCH);
  localparam int AC = 2 * W + $clog2(N);
  localparam logic signed [AC-1:0] MAXV = {{(AC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AC-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, OUT} state_t;
  state_t state, state_nx;
  logic [MW-1:0] clr_cnt, waddr, raddr;
  logic [AW-1:0] wp [NCH];
  logic [AW-1:0] base, rd;
  logic [CW-1:0] ch;
  logic [W-1:0] hist [N*NCH];
  logic [W-1:0] hist_q, wdata, y_nx;
  logic we, take, chan_ok, acc_en, sat_nx;
  logic signed [2*W-1:0] prod;
  logic signed [AC-1:0] acc, sum, res;
  assign chan_ok = 32'(x_chan) < NCH;
  assign take = state == IDLE && x_valid;
  always_comb begin
    state_nx = state;
    x_ready = state == IDLE;
    y_valid = state == OUT;
    case (state)
      CLEAR:   if (clr_cnt == MW'(N * NCH - 1)) state_nx = IDLE;
      IDLE:    if (take && chan_ok) state_nx = MAC;
      MAC:     if (coef_addr == AW'(N - 1)) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      OUT:     if (y_ready) state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end
  // history read walks backwards from the newest sample, wrapping mod N
  always_comb begin
    we = state == CLEAR || (take && chan_ok);
    waddr = state == CLEAR ? clr_cnt : MW'(x_chan) * MW'(N) + MW'(wp[x_chan]);
    wdata = state == CLEAR ? '0 : x_data;
    rd = base >= coef_addr ? base - coef_addr : base + AW'(N) - coef_addr;
    raddr = MW'(ch) * MW'(N) + MW'(rd);
    prod = $signed(hist_q) * $signed(coef_data);
    sum = acc + AC'(prod);
    res = sum >>> W_FRAC;
    sat_nx = res > MAXV || res < MINV;
    y_nx = res > MAXV ? {1'b0, {(W-1){1'b1}}} : res < MINV ? {1'b1, {(W-1){1'b0}}} : res[W-1:0];
    acc_en = (state == MAC && coef_addr != '0) || state == DRAIN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      for (int i = 0; i < NCH; i++) wp[i] <= '0;
      base <= '0;
      ch <= '0;
      acc <= '0;
      coef_addr <= '0;
      y_data <= '0;
      y_chan <= '0;
      y_sat <= 1'b0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + MW'(1);
      if (take && chan_ok) begin
        ch <= x_chan;
        base <= wp[x_chan];
        wp[x_chan] <= wp[x_chan] == AW'(N - 1) ? '0 : wp[x_chan] + AW'(1);
        acc <= '0;
        coef_addr <= '0;
      end
      if (state == MAC && coef_addr != AW'(N - 1)) coef_addr <= coef_addr + AW'(1);
      if (acc_en) acc <= sum;
      if (state == DRAIN) begin
        y_data <= y_nx;
        y_chan <= ch;
        y_sat <= sat_nx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we) hist[waddr] <= wdata;
    hist_q <= hist[raddr];
  end
endmodule
